// File: rtl/cpu_pkg.sv
`default_nettype none
// ==================================================================
// cpu_pkg : shared controller state encoding and memory commands
// Rev 1.0
// ==================================================================
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_IF   = 3'd1,
    ST_EXEC = 3'd2,
    ST_DMEM = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ==================================================================
// wait_timer : counts memory wait cycles, flags the last allowed one
// Rev 1.0
// ==================================================================
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the MAX_WAIT-th cycle of an access: a stall now is fatal.
  assign expired = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/fetch_mem_ctrl.sv
`default_nettype none
// ==================================================================
// fetch_mem_ctrl : PC/IR/DAR owner sharing one memory port for fetch and data
// Rev 1.0
// ==================================================================
module fetch_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [2:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              exec_done,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   dar_q, dar_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdr_q, wdr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                instr_valid_q, instr_valid_d;
  logic                d_done_q, d_done_d;
  logic                err_q, err_d;

  logic wait_clr, wait_inc, wait_expired;

  // Timer runs only while an access is outstanding; every other state clears it.
  assign wait_clr = !((state_q == ST_IF) || (state_q == ST_DMEM));
  assign wait_inc = !wait_clr && !mem_rdy;

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    dar_d         = dar_q;
    we_d          = we_q;
    wdr_d         = wdr_q;
    rdata_d       = rdata_q;
    instr_valid_d = 1'b0;
    d_done_d      = 1'b0;
    err_d         = err_q;
    case (state_q)
      ST_RST: state_d = ST_IF;
      ST_IF: begin
        if (mem_rdy) begin
          ir_d          = mem_rdata;
          pc_d          = pc_q + ADDR_W'(1);
          instr_valid_d = 1'b1;
          state_d       = ST_EXEC;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (d_req) begin
          dar_d   = d_addr;
          we_d    = d_we;
          wdr_d   = d_wdata;
          state_d = ST_DMEM;
        end else if (exec_done) begin
          if (br_valid) pc_d = br_target;
          state_d = halt ? ST_HALT : ST_IF;
        end
      end
      ST_DMEM: begin
        if (mem_rdy) begin
          d_done_d = 1'b1;
          if (!we_q) rdata_d = mem_rdata;
          state_d = ST_EXEC;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RST;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      dar_q         <= '0;
      we_q          <= 1'b0;
      wdr_q         <= '0;
      rdata_q       <= '0;
      instr_valid_q <= 1'b0;
      d_done_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      dar_q         <= dar_d;
      we_q          <= we_d;
      wdr_q         <= wdr_d;
      rdata_q       <= rdata_d;
      instr_valid_q <= instr_valid_d;
      d_done_q      <= d_done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    mem_cmd  = MNONE;
    mem_addr = pc_q;
    case (state_q)
      ST_IF:   mem_cmd = MREAD;
      ST_DMEM: begin
        mem_cmd  = we_q ? MWRITE : MREAD;
        mem_addr = dar_q;
      end
      default: mem_cmd = MNONE;
    endcase
  end

  assign mem_wdata   = wdr_q;
  assign instr       = ir_q;
  assign instr_valid = instr_valid_q;
  assign d_done      = d_done_q;
  assign d_rdata     = rdata_q;
  assign pc          = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_ctrl.sv
`default_nettype none
// ==================================================================
// tb_fetch_mem_ctrl : transaction-level bench with a memory/PC model
// Rev 1.0
// ==================================================================
module tb_fetch_mem_ctrl;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam logic [2:0] CMD_NONE  = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rdy = 1'b0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          exec_done = 1'b0;
  logic          br_valid = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic          halt = 1'b0;
  logic [AW-1:0] pc;
  logic          halted;
  logic          err;

  always #5 clk = ~clk;

  fetch_mem_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (9'h000),
    .MAX_WAIT (MW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_cmd     (mem_cmd),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rdy     (mem_rdy),
    .instr       (instr),
    .instr_valid (instr_valid),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_done      (d_done),
    .d_rdata     (d_rdata),
    .exec_done   (exec_done),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .halt        (halt),
    .pc          (pc),
    .halted      (halted),
    .err         (err)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] exp_pc;
  logic [DW-1:0] exp_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_quiet();
    d_req = 1'b0; exec_done = 1'b0; br_valid = 1'b0; halt = 1'b0; mem_rdy = 1'b0;
  endtask

  // Reset asserted a little after a falling edge; released on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    mem_rdy = 1'b1;
    #1;
    check_eq("rst_async_cmd", mem_cmd, CMD_NONE);
    check_eq("rst_async_pc", pc, 9'h000);
    @(negedge clk);
    drive_quiet();
    reset = 1'b1;
    exp_pc = '0;
    exp_rdata = '0;
    check_eq("rst_cmd", mem_cmd, CMD_NONE);
    check_eq("rst_addr", mem_addr, 9'h000);
    check_eq("rst_instr", instr, 16'h0000);
    check_eq("rst_drdata", d_rdata, 16'h0000);
    check_eq("rst_flags", {instr_valid, d_done, halted, err}, 4'b0000);
    @(negedge clk);
  endtask

  task automatic do_fetch(input int waits);
    for (int k = 0; k <= waits; k++) begin
      check_eq("if_cmd", mem_cmd, CMD_READ);
      check_eq("if_addr", mem_addr, exp_pc);
      if (k < waits) begin
        mem_rdy = 1'b0; mem_rdata = DW'($urandom);
      end else begin
        mem_rdy = 1'b1; mem_rdata = mem[exp_pc];
      end
      @(negedge clk);
    end
    mem_rdy = 1'b0;
    check_eq("if_valid", instr_valid, 1'b1);
    check_eq("if_instr", instr, mem[exp_pc]);
    check_eq("if_err", err, 1'b0);
    exp_pc = exp_pc + 9'd1;
    check_eq("if_pc", pc, exp_pc);
  endtask

  task automatic exec_idle(input int n);
    for (int k = 0; k < n; k++) begin
      d_req = 1'b0; exec_done = 1'b0;
      mem_rdy = 1'($urandom); mem_rdata = DW'($urandom);
      @(negedge clk);
      check_eq("ex_pulses", {instr_valid, d_done}, 2'b00);
      check_eq("ex_cmd", mem_cmd, CMD_NONE);
      check_eq("ex_pc", pc, exp_pc);
    end
    mem_rdy = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int waits);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    exec_done = 1'($urandom); br_valid = 1'($urandom); br_target = AW'($urandom);
    halt = 1'($urandom); mem_rdy = 1'($urandom);
    @(negedge clk);
    d_req = 1'b0; exec_done = 1'b0; br_valid = 1'b0; halt = 1'b0;
    d_addr = AW'($urandom); d_wdata = DW'($urandom); d_we = 1'($urandom);
    for (int k = 0; k <= waits; k++) begin
      check_eq("dm_cmd", mem_cmd, we ? CMD_WRITE : CMD_READ);
      check_eq("dm_addr", mem_addr, a);
      if (we) check_eq("dm_wdata", mem_wdata, wd);
      mem_rdy = (k == waits);
      mem_rdata = (k == waits && !we) ? mem[a] : DW'($urandom);
      @(negedge clk);
    end
    mem_rdy = 1'b0;
    if (we) mem[a] = wd;
    else exp_rdata = mem[a];
    check_eq("dm_done", d_done, 1'b1);
    check_eq("dm_rdata", d_rdata, exp_rdata);
    check_eq("dm_pc", pc, exp_pc);
    check_eq("dm_state_cmd", mem_cmd, CMD_NONE);
  endtask

  task automatic do_exec_done(input bit br, input logic [AW-1:0] t, input bit hlt);
    d_req = 1'b0; exec_done = 1'b1; br_valid = br; br_target = t; halt = hlt;
    @(negedge clk);
    drive_quiet();
    if (br) exp_pc = t;
    check_eq("ed_pc", pc, exp_pc);
    check_eq("ed_halted", halted, hlt);
    if (hlt) check_eq("ed_cmd", mem_cmd, CMD_NONE);
  endtask

  task automatic hold_halt(input int n);
    for (int k = 0; k < n; k++) begin
      mem_rdy = 1'($urandom); exec_done = 1'($urandom); d_req = 1'($urandom);
      @(negedge clk);
      check_eq("hl_halted", halted, 1'b1);
      check_eq("hl_cmd", mem_cmd, CMD_NONE);
    end
    drive_quiet();
  endtask

  task automatic do_timeout(input bit in_dmem);
    if (in_dmem) begin
      d_req = 1'b1; d_we = 1'($urandom); d_addr = AW'($urandom);
      @(negedge clk);
      d_req = 1'b0;
    end
    for (int k = 0; k < MW; k++) begin
      check_eq("to_pending", {halted, err}, 2'b00);
      mem_rdy = 1'b0;
      @(negedge clk);
    end
    check_eq("to_err", err, 1'b1);
    check_eq("to_halted", halted, 1'b1);
    check_eq("to_cmd", mem_cmd, CMD_NONE);
    check_eq("to_pulses", {instr_valid, d_done}, 2'b00);
    hold_halt(3);
    check_eq("to_err_sticky", err, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[0] = 16'hD105;
    mem[1] = 16'hE000;
    exp_pc = '0;
    exp_rdata = '0;

    apply_reset();
    do_fetch(0);
    check_eq("first_instr", instr, 16'hD105);
    exec_idle(1);
    do_exec_done(1'b0, '0, 1'b0);
    do_fetch(0);
    check_eq("second_pc", pc, 9'h002);

    do_exec_done(1'b0, '0, 1'b0);
    do_fetch(MW - 1);
    exec_idle(2);

    do_data(1'b1, 9'h01F, 16'hBEEF, 2);
    exec_idle(1);
    do_data(1'b0, 9'h01F, 16'h1234, 1);
    check_eq("load_beef", d_rdata, 16'hBEEF);
    do_data(1'b1, 9'h020, 16'h5A5A, 0);
    check_eq("store_keeps_rdata", d_rdata, 16'hBEEF);

    do_exec_done(1'b1, 9'h004, 1'b0);
    do_fetch(0);
    do_exec_done(1'b1, 9'h040, 1'b0);
    do_fetch(1);
    do_exec_done(1'b1, 9'h1FF, 1'b0);
    do_fetch(0);
    check_eq("pc_wrap", pc, 9'h000);

    do_exec_done(1'b0, '0, 1'b0);
    do_fetch(0);
    do_timeout(1'b1);
    apply_reset();
    do_timeout(1'b0);
    apply_reset();

    do_fetch(0);
    do_exec_done(1'b1, 9'h0AB, 1'b1);
    hold_halt(2);
    apply_reset();
    do_fetch(0);

    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h033;
    @(negedge clk);
    d_req = 1'b0;
    apply_reset();
    check_eq("midrst_pulses", {instr_valid, d_done}, 2'b00);
    do_fetch(0);

    for (int it = 0; it < 150; it++) begin
      int nd;
      exec_idle($urandom_range(0, 2));
      nd = $urandom_range(0, 2);
      for (int j = 0; j < nd; j++) begin
        do_data(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, MW - 1));
        exec_idle($urandom_range(0, 1));
      end
      do_exec_done(($urandom % 4) == 0, AW'($urandom), 1'b0);
      do_fetch($urandom_range(0, MW - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fetch_mem_ctrl.md
# fetch_mem_ctrl

Parametrised fetch/memory sequencer for the multi-cycle CPU: owns the program counter, instruction register and data-address register, and multiplexes instruction fetch and data load/store onto one shared memory port. Unlike the fixed-latency controller, it handles variable memory latency through a `mem_rdy` handshake and supports branch redirection, halt and a wait-state timeout. It sits between the unified memory and the execute state machine/datapath.

## Interface
Parameters:
- `ADDR_W`, default 9: PC, data-address and `mem_addr` width.
- `DATA_W`, default 16: instruction and data word width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `MAX_WAIT`, default 15: maximum cycles a memory access may wait for `mem_rdy`; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_cmd`  out  3  memory command, one-hot: MNONE=001, MREAD=010, MWRITE=100.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  store data.
- `mem_rdata`  in  DATA_W  load/fetch data; valid when `mem_rdy`=1.
- `mem_rdy`  in  1  access complete this cycle.
- `instr`  out  DATA_W  instruction register.
- `instr_valid`  out  1  one-cycle pulse when `instr` is newly loaded.
- `d_req`  in  1  executor requests a data access (sampled only in EXEC).
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_done`  out  1  one-cycle pulse when the data access completes.
- `d_rdata`  out  DATA_W  load result; holds until the next load completes.
- `exec_done`  in  1  current instruction finished.
- `br_valid`  in  1  with `exec_done`: take the branch.
- `br_target`  in  ADDR_W  branch destination.
- `halt`  in  1  with `exec_done`: enter HALT.
- `pc`  out  ADDR_W  current PC.
- `halted`  out  1  controller is in HALT.
- `err`  out  1  sticky flag: a memory access timed out.

## Operation
- States: RST, IF, EXEC, DMEM, HALT. Moore outputs derive from the state register and the PC/DAR/IR registers.
- RST: `mem_cmd`=MNONE. Transitions unconditionally to IF.
- IF: `mem_cmd`=MREAD, `mem_addr`=`pc`.
  - On `mem_rdy`: `instr` <= `mem_rdata`; `pc` <= `pc`+1, wrapping modulo 2^ADDR_W; `instr_valid` pulses next cycle; go to EXEC.
- EXEC: `mem_cmd`=MNONE, `mem_addr`=`pc`.
  - `d_req`=1: latch `d_addr`, `d_we`, `d_wdata` into DAR/WE/WDR; go to DMEM. `d_req` wins over a simultaneous `exec_done`, which is dropped.
  - Else `exec_done`=1: if `br_valid`, `pc` <= `br_target`. Then, if `halt`, go to HALT; otherwise go to IF. Branch and halt may coincide: the PC updates, then the controller halts.
- DMEM: `mem_cmd`=MWRITE if WE else MREAD; `mem_addr`=DAR; `mem_wdata`=WDR.
  - On `mem_rdy`: `d_done` pulses next cycle; for a load, `d_rdata` <= `mem_rdata`; go to EXEC.
- HALT: `mem_cmd`=MNONE, `halted`=1. Only reset exits this state.
- Wait timer: cleared on entry to IF or DMEM, increments each cycle `mem_rdy`=0. When it reaches MAX_WAIT without `mem_rdy`, set `err`=1 and go to HALT. `mem_rdy` arriving on the MAX_WAIT-th cycle counts as success.
- `mem_wdata` is driven from WDR in all states; its value is meaningful only in DMEM.

## Timing
- Reset (asynchronous assert, synchronous release): state=RST, `pc`=RESET_PC, `instr`=0, DAR=0, WDR=0, `d_rdata`=0, `instr_valid`=0, `d_done`=0, `halted`=0, `err`=0, `mem_cmd`=MNONE, `mem_addr`=RESET_PC.
- Reset asserted mid-access: the command drops to MNONE immediately; no completion pulse is produced.
- Fetch latency: IF lasts 1 + (number of cycles with `mem_rdy`=0) cycles. `instr_valid` is asserted in the first EXEC cycle.
- Best-case throughput with `mem_rdy` tied to 1 and no data access: 2 cycles per instruction.
- A data access occupies 1 + wait cycles in DMEM. `d_done` is asserted in the first EXEC cycle after DMEM.
- `mem_rdy` is ignored in RST, EXEC and HALT.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (RST, IF, EXEC, DMEM, HALT);
  - MNONE/MREAD/MWRITE constants.
- Sub-module `wait_timer` (parameter MAX_WAIT): inputs `clr` and `inc`; output `expired`. It is the only natural split. PC, IR, DAR and the FSM stay in the top module.

## Test plan
- Release reset with `mem_rdy`=1 and memory[0]=16'hD105, memory[1]=16'hE000 → MREAD at address 0; `instr_valid` with `instr`=16'hD105; after `exec_done`, MREAD at address 1 and `pc`=2.
- Fetch with `mem_rdy` low for 3 cycles (MAX_WAIT=15) → MREAD held 4 cycles; `instr` loaded exactly once; `err`=0.
- In EXEC, `d_req`=1, `d_we`=1, `d_addr`=9'h1F, `d_wdata`=16'hBEEF → MWRITE with `mem_addr`=9'h1F and `mem_wdata`=16'hBEEF; `d_done` pulses once; next a load from 9'h1F returns `d_rdata`=16'hBEEF.
- `exec_done`+`br_valid` with `br_target`=9'h040 at `pc`=9'h005 → next fetch address 9'h040; with ADDR_W=9 and `pc`=9'h1FF, a fetch wraps `pc` to 0.
- Hold `mem_rdy`=0 in DMEM with MAX_WAIT=4 → after 4 wait cycles, `err`=1, `halted`=1, `mem_cmd`=MNONE; stays there until reset, which clears both flags.
- `exec_done`+`halt` → HALT with `mem_cmd`=MNONE; asserting `reset` low mid-HALT returns `pc`=RESET_PC and fetching resumes.
